// File: rtl/led_pkg.sv
// Shared types and constants for the LED sequencer: FSM encoding, LED width
// and the default lit pattern.
package led_pkg;

    localparam int LED_W = 12;
    localparam logic [LED_W-1:0] BASE_PATTERN_DEF = 12'b001100110010;

    typedef enum logic [1:0] {
        ROTATE = 2'd0,
        PAUSE  = 2'd1,
        BLINK  = 2'd2,
        FILL   = 2'd3
    } state_t;

    // Mode button walks the states in encoding order and wraps.
    function automatic state_t next_mode(input state_t s);
        logic [1:0] v;
        v = s;
        return state_t'(v + 2'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-time debouncer and a single
// cycle pulse on each debounced press (active-low input).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // cnt counts consecutive samples that disagree with the debounced level;
    // the level flips on the DEBOUNCE_CYCLES-th one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // High in the cycle whose edge commits a 1->0 level change.
    assign press = (s2 != stable) && (cnt == CNT_MAX) && !s2;

endmodule

// File: rtl/led_seq_ctrl.sv
// 12-LED pattern sequencer: ROTATE / PAUSE / BLINK / FILL modes stepped by a
// speed-scaled tick, controlled by two debounced push buttons.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int               TICK_BASE       = 1 << 25,
    parameter int               DEBOUNCE_CYCLES = 1 << 16,
    parameter logic [LED_W-1:0] BASE_PATTERN    = BASE_PATTERN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_speed,
    input  logic             direction,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic [1:0]       speed
);

    localparam int TW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;

    logic             mode_press;
    logic             speed_press;
    logic [TW-1:0]    tcnt;
    logic [TW-1:0]    tlim;
    logic             tick;
    state_t           state;
    state_t           state_nxt;
    logic [LED_W-1:0] pattern;
    logic [LED_W-1:0] pat_nxt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_speed),
        .press (speed_press)
    );

    assign tlim = TW'((TICK_BASE >> speed) - 1);
    assign tick = (tcnt == tlim);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt  <= '0;
            speed <= 2'd0;
        end else begin
            tcnt <= (speed_press || tick) ? '0 : tcnt + 1'b1;
            if (speed_press)
                speed <= speed + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ROTATE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mode_press)
            state_nxt = next_mode(state);
    end

    // A mode change takes priority: the entry action replaces any tick step.
    always_comb begin
        pat_nxt = pattern;
        if (mode_press) begin
            case (state_nxt)
                ROTATE:  pat_nxt = BASE_PATTERN;
                FILL:    pat_nxt = '0;
                default: pat_nxt = pattern;
            endcase
        end else if (tick) begin
            case (state)
                ROTATE:  pat_nxt = direction ? {pattern[LED_W-2:0], pattern[LED_W-1]}
                                             : {pattern[0], pattern[LED_W-1:1]};
                BLINK:   pat_nxt = ~pattern;
                FILL:    pat_nxt = (&pattern) ? '0 : {pattern[LED_W-2:0], 1'b1};
                default: pat_nxt = pattern;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= BASE_PATTERN;
            led     <= ~BASE_PATTERN;
        end else begin
            pattern <= pat_nxt;
            led     <= ~pat_nxt;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl (TICK_BASE=16, DEBOUNCE_CYCLES=4): every
// output change is popped against the next expected entry, including its spacing.
module tb_led_seq_ctrl;

    localparam logic [11:0] BASE = 12'b001100110010;

    typedef struct {
        logic [11:0] led;
        logic [1:0]  mode;
        logic [1:0]  speed;
        int          gap;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        btn_mode;
    logic        btn_speed;
    logic        direction;
    logic [11:0] led;
    logic [1:0]  mode;
    logic [1:0]  speed;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          t       = 0;
    int          cyc     = 0;
    logic [15:0] last;
    logic [11:0] ep;
    logic [1:0]  em;
    logic [1:0]  es;

    led_seq_ctrl #(.TICK_BASE(16), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_speed (btn_speed),
        .direction (direction),
        .led       (led),
        .mode      (mode),
        .speed     (speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic push(input int gap);
        exp_t e;
        e.led   = ~ep;
        e.mode  = em;
        e.speed = es;
        e.gap   = gap;
        sb.push_back(e);
    endtask

    // n tick steps in ROTATE, each expected gap cycles after the previous change
    task automatic rot(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            ep = direction ? {ep[10:0], ep[11]} : {ep[0], ep[11:1]};
            push(gap);
        end
    endtask

    task automatic fill(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            ep = (ep == 12'hFFF) ? 12'h000 : {ep[10:0], 1'b1};
            push(gap);
        end
    endtask

    task automatic step_to(input int n);
        while (t < n) begin
            @(negedge clk);
            t++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cyc  = 0;
            last = {led, mode, speed};
        end else begin
            cyc++;
            if ({led, mode, speed} != last) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 32'({led, mode, speed}), 32'(last));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("led",   32'(led),   32'(e.led));
                    chk("mode",  32'(mode),  32'(e.mode));
                    chk("speed", 32'(speed), 32'(e.speed));
                    if (e.gap != 0)
                        chk("gap", 32'(cyc), 32'(e.gap));
                end
                last = {led, mode, speed};
                cyc  = 0;
            end
        end
    end

    initial begin
        rst = 1'b0; btn_mode = 1'b1; btn_speed = 1'b1; direction = 1'b1;
        ep = BASE; em = 2'd0; es = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_led",   32'(led),   32'(12'b110011001101));
        chk("rst_mode",  32'(mode),  32'd0);
        chk("rst_speed", 32'(speed), 32'd0);
        @(negedge clk); #2 rst = 1'b1; t = 0;

        rot(4, 16);
        step_to(48);  btn_mode = 1'b0;        // 3-cycle glitch: must be ignored
        step_to(51);  btn_mode = 1'b1;
        step_to(64);  btn_mode = 1'b0; em = 2'd1; push(0);
        step_to(74);  btn_mode = 1'b1;

        // PAUSE -> BLINK on a tick edge, then FILL on a tick edge
        step_to(106); btn_mode = 1'b0; em = 2'd2; push(0);
        ep = ~ep; push(16);
        step_to(116); btn_mode = 1'b1;
        step_to(138); btn_mode = 1'b0; em = 2'd3; ep = 12'h000; push(0);
        fill(13, 16);
        step_to(148); btn_mode = 1'b1;

        // back to ROTATE, rotate right
        step_to(354); btn_mode = 1'b0; direction = 1'b0; em = 2'd0; ep = BASE; push(0);
        rot(1, 8);
        step_to(364); btn_mode = 1'b1;

        // speed 1, 2, 3, 0
        step_to(368); btn_speed = 1'b0; es = 2'd1; push(0); rot(2, 8);
        step_to(376); btn_speed = 1'b1;
        step_to(390); btn_speed = 1'b0; es = 2'd2; push(0); rot(5, 4);
        step_to(398); btn_speed = 1'b1;
        step_to(413); btn_speed = 1'b0; es = 2'd3; push(0); rot(9, 2);
        step_to(421); btn_speed = 1'b1;
        step_to(432); btn_speed = 1'b0; es = 2'd0; push(0); rot(1, 16);
        step_to(440); btn_speed = 1'b1;

        // simultaneous mode+speed presses into BLINK at speed 2
        step_to(454); btn_mode = 1'b0; btn_speed = 1'b0; em = 2'd1; es = 2'd1; push(0);
        step_to(462); btn_mode = 1'b1; btn_speed = 1'b1;
        step_to(480); btn_mode = 1'b0; btn_speed = 1'b0; em = 2'd2; es = 2'd2; push(0);
        ep = ~ep; push(4);
        ep = ~ep; push(4);
        step_to(488); btn_mode = 1'b1; btn_speed = 1'b1;

        step_to(495);
        chk("sb_pre_rst", 32'(sb.size()), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("arst_led",   32'(led),   32'(12'b110011001101));
        chk("arst_mode",  32'(mode),  32'd0);
        chk("arst_speed", 32'(speed), 32'd0);
        ep = BASE; em = 2'd0; es = 2'd0;
        repeat (3) @(negedge clk);
        @(negedge clk); #2 rst = 1'b1; t = 0;
        rot(2, 16);
        step_to(40);
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_BASE, default 2^25, meaning the step period in clk cycles at speed 0.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 2^16, meaning the required stable-input duration in clk cycles.
REQ-003 SHALL have parameter BASE_PATTERN, default 12'b001100110010, meaning the lit-LED pattern (1 = lit) loaded at reset and on entering ROTATE.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_mode, input, 1 bit: raw mode button, asynchronous, active-low (pressed = 0).
REQ-007 SHALL have port btn_speed, input, 1 bit: raw speed button, asynchronous, active-low.
REQ-008 SHALL have port direction, input, 1 bit: 1 = rotate left (bit 11 wraps to bit 0), 0 = rotate right; sampled only on a tick.
REQ-009 SHALL have port led, output, 12 bits, registered: active-low LED drive, led = ~pattern.
REQ-010 SHALL have port mode, output, 2 bits, registered: current FSM state.
REQ-011 SHALL have port speed, output, 2 bits, registered: current speed level, 0..3.

Function
REQ-012 Tick generator SHALL count 0..(TICK_BASE>>speed)-1, then emit a 1-cycle internal tick and wrap to 0.
REQ-013 Each button SHALL pass through a 2-FF synchronizer, then a debouncer; the debounced level updates only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-014 A debounced 1->0 transition SHALL produce exactly one 1-cycle press pulse; release SHALL produce none; holding SHALL produce none.
REQ-015 Speed press SHALL set speed to (speed+1) mod 4 (3 wraps to 0) and clear the tick counter in the same cycle.
REQ-016 FSM states SHALL be ROTATE=0, PAUSE=1, BLINK=2, FILL=3; a mode press SHALL advance ROTATE->PAUSE->BLINK->FILL->ROTATE.
REQ-017 ROTATE: on tick, pattern SHALL rotate by one position per direction; entering ROTATE SHALL reload BASE_PATTERN.
REQ-018 PAUSE: pattern SHALL hold; ticks SHALL be ignored.
REQ-019 BLINK: on tick, pattern SHALL invert bitwise; entering BLINK SHALL keep the current pattern.
REQ-020 FILL: entering FILL SHALL clear pattern to 0; on tick, pattern SHALL become {pattern[10:0],1'b1}; on a tick with pattern = 12'hFFF, pattern SHALL become 0.
REQ-021 When a mode press and a tick coincide, the state transition and entry action SHALL win; that tick SHALL not alter the pattern.
REQ-022 Mode and speed presses in the same cycle SHALL both take effect.
REQ-023 led, mode and speed SHALL update on the clk edge after the causing event (1-cycle latency from tick or press).

Reset
REQ-024 On rst=0, pattern SHALL be BASE_PATTERN (led = ~BASE_PATTERN = 12'b110011001101), mode = ROTATE, speed = 0, tick counter = 0, synchronizers and debounced levels = 1 (released), debounce counters = 0.
REQ-025 Reset asserted mid-operation SHALL take effect asynchronously; deassertion SHALL resume from reset values with no spurious press pulse.

Structure
REQ-026 Package led_pkg SHALL hold the state typedef/encodings, the 12-bit LED width constant and the default BASE_PATTERN.
REQ-027 Sub-module btn_debounce (synchronizer + debouncer + press pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification (TICK_BASE=16, DEBOUNCE_CYCLES=4)
REQ-028 Reset release, direction=1, no presses -> led = 12'b110011001101, then after 16 cycles pattern = 12'b011001100100, one rotate-left step every 16 cycles.
REQ-029 btn_mode low for 3 cycles, then high -> no mode change; low for 10 cycles -> mode advances exactly once (0->1) and led holds through later ticks.
REQ-030 Four speed presses -> speed 1,2,3,0; step period 8,4,2,16 cycles; tick counter restarts at each press.
REQ-031 Mode presses to FILL -> pattern 0, then 12 ticks reach 12'hFFF, and the 13th tick gives 0.
REQ-032 Press timed so the pulse coincides with a tick in PAUSE -> mode = BLINK, pattern unchanged that cycle, inverted on the next tick.
REQ-033 Assert rst in BLINK at speed 2 -> outputs return immediately to the REQ-024 values, with no press pulse after release.
